// File: rtl/mem_access_unit.sv
// Load/store responder between the multicycle core and Memoria.
// Sub-word loads are extracted here; sub-word stores use read-modify-write.
module mem_access_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW =
    (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  off;
    logic [31:0] wdata;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        ready_q, ready_d;
  logic        rv_q, rv_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req_bad;
  logic        req_direct_wr;

  function automatic logic [31:0] load_ext(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  off,
    input logic        sgn
  );
    logic [31:0] sh;
    logic [31:0] res;
    sh  = word >> {off, 3'b000};
    res = word;
    unique case (size)
      2'b00: res = sgn ? {{24{sh[7]}}, sh[7:0]}
                       : {24'b0, sh[7:0]};
      2'b01: res = sgn ? {{16{sh[15]}}, sh[15:0]}
                       : {16'b0, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  off,
    input logic [31:0] data
  );
    logic [31:0] mask;
    mask = (size == 2'b00) ? 32'h0000_00ff
                           : 32'h0000_ffff;
    return (word & ~(mask << {off, 3'b000}))
         | ((data & mask) << {off, 3'b000});
  endfunction

  always_comb begin
    req_bad = 1'b0;
    unique case (1'b1)
      (req_size == 2'b11): req_bad = 1'b1;
      (req_size == 2'b01): req_bad = req_addr[0];
      (req_size == 2'b10): req_bad = |req_addr[1:0];
      default:             req_bad = 1'b0;
    endcase
  end

  assign req_direct_wr = req_we && (req_size == 2'b10);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rv_d    = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wr_d    = 1'b0;
    wdata_d = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d.we    = req_we;
          req_d.size  = req_size;
          req_d.sgn   = req_signed;
          req_d.off   = req_addr[1:0];
          req_d.wdata = req_wdata;
          cnt_d       = '0;
          if (req_bad) begin
            state_d = RESP;
            rv_d    = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            addr_d = {req_addr[31:2], 2'b00};
            if (req_direct_wr) begin
              state_d = WR;
              wr_d    = 1'b1;
              wdata_d = req_wdata;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        if (cnt_q == CNT_LAST) begin
          if (req_q.we) begin
            state_d = WR;
            wr_d    = 1'b1;
            wdata_d = merge(mem_rdata, req_q.size,
                            req_q.off, req_q.wdata);
          end else begin
            state_d = RESP;
            rv_d    = 1'b1;
            rdata_d = load_ext(mem_rdata, req_q.size,
                               req_q.off, req_q.sgn);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR: begin
        state_d = RESP;
        rv_d    = 1'b1;
        rdata_d = '0;
      end
      RESP: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = rv_q;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = addr_q;
  assign mem_wr     = wr_q;
  assign mem_wdata  = wdata_q;

endmodule
